tpu_axil_csr: RTL and testbench

TPU_AXIL_CSR -- requirements
Module: tpu_axil_csr

---
 rtl/tpu_axil_csr.sv | 162 ++++++++++++++++
 tb/tb_tpu_axil_csr.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_axil_csr.sv
// AXI4-Lite control/status block for the TPU layer controller: start pulse,
// busy/done tracking with a saturating cycle counter, and a level interrupt.
module tpu_axil_csr #(
  parameter logic [31:0] VERSION = 32'h2022_0001,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  // write address / data / response
  input  logic [3:0]  s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  // read address / data
  input  logic [3:0]  s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  // layer controller
  output logic        start_o,
  input  logic        done_i,
  output logic        irq_o
);

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CYCLES  = 2'd2;
  localparam logic [1:0] ADDR_VERSION = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             busy_q;
  logic             done_q;
  logic             irq_en_q;
  logic             done_prev_q;
  logic [CNT_W-1:0] cycles_q;

  logic        wr_hs_c;
  logic        wr_en_c;
  logic        rd_hs_c;
  logic        start_req_c;
  logic        done_set_c;
  logic        done_clr_c;
  logic [31:0] rd_data_c;
  logic        unused_ok;

  // Handshakes complete in the cycle the readies are high; held off while a response is pending
  assign wr_hs_c   = s_awvalid & s_wvalid & ~s_bvalid & ~rst;
  assign rd_hs_c   = s_arvalid & ~s_rvalid & ~rst;
  assign s_awready = wr_hs_c;
  assign s_wready  = wr_hs_c;
  assign s_arready = rd_hs_c;
  assign s_bresp   = 2'b00;
  assign s_rresp   = 2'b00;

  // Only byte lane 0 carries implemented bits
  assign wr_en_c     = wr_hs_c & s_wstrb[0];
  assign start_req_c = wr_en_c && (s_awaddr[3:2] == ADDR_CTRL) && s_wdata[0] && !busy_q;
  assign done_clr_c  = wr_en_c && (s_awaddr[3:2] == ADDR_STATUS) && s_wdata[1];
  assign done_set_c  = done_i & ~done_prev_q & busy_q;

  assign unused_ok = ^{s_wdata[31:2], s_wstrb[3:1], s_awaddr[1:0], s_araddr[1:0]};

  // Read mux; unimplemented bits read as zero
  always_comb begin
    rd_data_c = 32'h0;
    case (s_araddr[3:2])
      ADDR_CTRL:    rd_data_c = {30'h0, irq_en_q, 1'b0};
      ADDR_STATUS:  rd_data_c = {30'h0, done_q, busy_q};
      ADDR_CYCLES:  rd_data_c = 32'(cycles_q);
      ADDR_VERSION: rd_data_c = VERSION;
      default:      rd_data_c = 32'h0;
    endcase
  end

  // Control register and start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      start_o  <= 1'b0;
    end else begin
      start_o <= start_req_c;
      if (wr_en_c && (s_awaddr[3:2] == ADDR_CTRL)) begin
        irq_en_q <= s_wdata[1];
      end
    end
  end

  // Busy/done tracking; a done set beats a same-cycle W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= done_i;
      if (start_req_c) begin
        busy_q <= 1'b1;
      end else if (done_set_c) begin
        busy_q <= 1'b0;
      end
      if (done_set_c) begin
        done_q <= 1'b1;
      end else if (start_req_c || done_clr_c) begin
        done_q <= 1'b0;
      end
    end
  end

  // Saturating run-length counter, restarted by each accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q <= '0;
    end else if (start_req_c) begin
      cycles_q <= '0;
    end else if (busy_q && (cycles_q != CNT_MAX)) begin
      cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  // Interrupt follows enabled DONE one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en_q & done_q;
    end
  end

  // Write response channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_bvalid <= 1'b0;
    end else if (wr_hs_c) begin
      s_bvalid <= 1'b1;
    end else if (s_bready) begin
      s_bvalid <= 1'b0;
    end
  end

  // Read data channel; data is held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
    end else if (rd_hs_c) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_data_c;
    end else if (s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tpu_axil_csr.sv
// Testbench for tpu_axil_csr: register table, directed corner sequences,
// and random traffic checked cycle by cycle against a behavioural model.
module tb_tpu_axil_csr;

  localparam int unsigned CNT_W   = 8;
  localparam logic [31:0] VER     = 32'h2022_0001;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [3:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        start_o;
  logic        done_i;
  logic        irq_o;

  tpu_axil_csr #(.VERSION(VER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .start_o(start_o), .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state (register-map view of the block)
  logic        m_busy, m_done, m_irq_en, m_prev, m_start, m_irq, m_bvalid, m_rvalid;
  logic [31:0] m_cycles, m_rdata;

  int errors = 0;
  int checks = 0;
  int start_seen = 0;
  int edges = 0;
  int wr_edge = 0;
  int rd_edge = 0;

  typedef struct {
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_irq_en = 0; m_prev = 0; m_start = 0; m_irq = 0;
    m_bvalid = 0; m_rvalid = 0; m_cycles = 0; m_rdata = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {30'h0, m_irq_en, 1'b0};
      2'd1:    return {30'h0, m_done, m_busy};
      2'd2:    return m_cycles;
      default: return VER;
    endcase
  endfunction

  // One clock: advance the model with the current inputs, then compare after the edge
  task automatic tick();
    logic aw, ar;
    logic n_busy, n_done, n_irq_en, n_prev, n_start, n_irq, n_bvalid, n_rvalid;
    logic [31:0] n_cycles, n_rdata;
    aw = s_awvalid & s_wvalid & ~m_bvalid;
    ar = s_arvalid & ~m_rvalid;
    n_busy = m_busy; n_done = m_done; n_irq_en = m_irq_en; n_cycles = m_cycles;
    n_bvalid = m_bvalid; n_rvalid = m_rvalid; n_rdata = m_rdata;
    n_prev = done_i;
    n_start = 0;
    n_irq = m_irq_en & m_done;
    if (m_busy && m_cycles != CNT_MAX) n_cycles = m_cycles + 1;
    if (ar) begin
      n_rvalid = 1;
      n_rdata  = m_read(s_araddr[3:2]);
    end else if (s_rready) n_rvalid = 0;
    if (aw) n_bvalid = 1;
    else if (s_bready) n_bvalid = 0;
    if (aw && s_wstrb[0]) begin
      if (s_awaddr[3:2] == 2'd0) begin
        n_irq_en = s_wdata[1];
        if (s_wdata[0] && !m_busy) begin
          n_start = 1; n_busy = 1; n_done = 0; n_cycles = 0;
        end
      end else if (s_awaddr[3:2] == 2'd1 && s_wdata[1]) begin
        n_done = 0;
      end
    end
    if (done_i && !m_prev && m_busy) begin
      n_busy = 0; n_done = 1;
    end
    @(posedge clk);
    #1;
    edges++;
    if (rst) m_reset();
    else begin
      m_busy = n_busy; m_done = n_done; m_irq_en = n_irq_en; m_prev = n_prev;
      m_start = n_start; m_irq = n_irq; m_bvalid = n_bvalid; m_rvalid = n_rvalid;
      m_cycles = n_cycles; m_rdata = n_rdata;
    end
    chk("start_o", start_o, m_start);
    chk("irq_o", irq_o, m_irq);
    chk("bvalid", s_bvalid, m_bvalid);
    chk("rvalid", s_rvalid, m_rvalid);
    chk("rdata", s_rdata, m_rdata);
    chk("bresp", s_bresp, 2'b00);
    chk("rresp", s_rresp, 2'b00);
    chk("awready", s_awready, s_awvalid & s_wvalid & ~m_bvalid & ~rst);
    chk("wready", s_wready, s_awvalid & s_wvalid & ~m_bvalid & ~rst);
    chk("arready", s_arready, s_arvalid & ~m_rvalid & ~rst);
    if (start_o) start_seen++;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st);
    bit got = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (s_bvalid) begin
        got = 1;
        wr_edge = edges;
      end
    end
    if (!got) chk("write_timeout", 32'(got), 32'd1);
    s_awvalid = 0; s_wvalid = 0;
    tick();
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit got = 0;
    d = 32'hDEAD_BEEF;
    s_araddr = a; s_arvalid = 1; s_rready = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (s_rvalid) begin
        got = 1;
        d = s_rdata;
        rd_edge = edges;
      end
    end
    if (!got) chk("read_timeout", 32'(got), 32'd1);
    s_arvalid = 0;
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] c1, c2, v0;
    int ss, e1, done_edge;

    vt[0] = '{4'h0, 32'h0000_0002, 4'hF, 4'h0, 32'h0000_0002};
    vt[1] = '{4'h0, 32'h0000_0000, 4'hE, 4'h0, 32'h0000_0002};
    vt[2] = '{4'h0, 32'h0000_0000, 4'h1, 4'h0, 32'h0000_0000};
    vt[3] = '{4'hC, 32'hFFFF_FFFF, 4'hF, 4'hC, 32'h2022_0001};
    vt[4] = '{4'h8, 32'h0000_1234, 4'hF, 4'h8, 32'h0000_0000};
    vt[5] = '{4'h4, 32'h0000_0003, 4'hF, 4'h4, 32'h0000_0000};
    vt[6] = '{4'h0, 32'hFFFF_FFFE, 4'hF, 4'h0, 32'h0000_0002};
    vt[7] = '{4'h3, 32'h0000_0000, 4'hF, 4'h1, 32'h0000_0000};

    rst = 1; done_i = 0;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0;
    m_reset();
    repeat (3) tick();
    rst = 0;
    tick();

    // Register table: write then read back
    for (int i = 0; i < 8; i++) begin
      axi_write(vt[i].waddr, vt[i].wdata, vt[i].wstrb);
      rd_chk($sformatf("table%0d", i), vt[i].raddr, vt[i].exp);
    end

    // Start with IRQ enabled
    ss = start_seen;
    axi_write(4'h0, 32'h3, 4'hF);
    e1 = wr_edge;
    repeat (2) tick();
    chk("start_pulse_count", 32'(start_seen - ss), 32'd1);
    rd_chk("status_busy", 4'h4, 32'h1);
    rd_chk("ctrl_irq_en", 4'h0, 32'h2);

    // Run 100 idle cycles, then done
    repeat (100) tick();
    done_i = 1;
    tick();
    done_edge = edges;
    tick();
    chk("irq_after_done", irq_o, 1'b1);
    rd_chk("status_done", 4'h4, 32'h2);
    rd_chk("cycles_run", 4'h8, 32'(done_edge - e1));
    axi_write(4'h4, 32'h2, 4'hF);
    tick();
    chk("irq_cleared", irq_o, 1'b0);
    rd_chk("status_w1c", 4'h4, 32'h0);

    // START while busy is ignored, counter keeps running
    done_i = 0;
    axi_write(4'h0, 32'h3, 4'hF);
    ss = start_seen;
    axi_write(4'h0, 32'h3, 4'hF);
    tick();
    chk("no_pulse_when_busy", 32'(start_seen - ss), 32'd0);
    axi_read(4'h8, c1);
    e1 = rd_edge;
    repeat (3) tick();
    axi_read(4'h8, c2);
    chk("cycles_advance", c2 - c1, 32'(rd_edge - e1));
    rd_chk("still_busy", 4'h4, 32'h1);

    // W1C of DONE on the same edge as a done rise: set wins
    s_awaddr = 4'h4; s_wdata = 32'h2; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_bready = 1; done_i = 1;
    tick();
    chk("coincident_hs", s_bvalid, 1'b1);
    s_awvalid = 0; s_wvalid = 0;
    tick();
    rd_chk("done_set_wins", 4'h4, 32'h2);

    // Back-pressure on both response channels
    s_bready = 0; s_rready = 0;
    s_awaddr = 4'h0; s_wdata = 32'h0; s_wstrb = 4'h0; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 4'hC; s_arvalid = 1;
    tick();
    v0 = s_rdata;
    chk("version_read", v0, VER);
    for (int i = 0; i < 5; i++) begin
      s_araddr = 4'h4;
      tick();
      chk("stall_bvalid", s_bvalid, 1'b1);
      chk("stall_rvalid", s_rvalid, 1'b1);
      chk("stall_rdata", s_rdata, v0);
      chk("stall_awready", s_awready, 1'b0);
      chk("stall_arready", s_arready, 1'b0);
    end
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    tick();
    rd_chk("wstrb0_no_change", 4'h0, 32'h2);

    // Counter saturation
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (300) tick();
    rd_chk("cycles_saturate", 4'h8, CNT_MAX);
    rd_chk("busy_long", 4'h4, 32'h1);

    // Asynchronous reset while busy with a read response pending
    s_araddr = 4'h8; s_arvalid = 1; s_rready = 0;
    tick();
    s_arvalid = 0;
    #2;
    s_awvalid = 1; s_wvalid = 1;
    rst = 1;
    #1;
    chk("rst_start_o", start_o, 1'b0);
    chk("rst_irq_o", irq_o, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_rdata", s_rdata, 32'h0);
    chk("rst_awready", s_awready, 1'b0);
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_arready", s_arready, 1'b0);
    s_awvalid = 0; s_wvalid = 0;
    tick();
    rst = 0; s_rready = 1;
    ss = start_seen;
    repeat (3) tick();
    chk("no_pulse_after_rst", 32'(start_seen - ss), 32'd0);
    rd_chk("status_after_rst", 4'h4, 32'h0);
    rd_chk("cycles_after_rst", 4'h8, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      s_awaddr  = 4'($urandom_range(0, 15));
      s_araddr  = 4'($urandom_range(0, 15));
      s_wdata   = $urandom;
      s_wstrb   = 4'($urandom_range(0, 15));
      s_awvalid = 1'($urandom_range(0, 1));
      s_wvalid  = 1'($urandom_range(0, 1));
      s_arvalid = 1'($urandom_range(0, 1));
      s_bready  = 1'($urandom_range(0, 1));
      s_rready  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) done_i = ~done_i;
      tick();
    end
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
